// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: walks start/data/parity/stop bits on an
// oversampled clock and reports the payload or a parity/stop error.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Sampled_bit,
  output logic                  Sample_En,
  output logic [4:0]            Edge_count,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level
  // START  | timing the start bit, glitch check at its end
  // DATA   | shifting payload bits in, LSB first
  // PARITY | checking the parity bit
  // STOP   | checking the stop bit, reporting the frame
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_nxt;
  logic [5:0]            p_l;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  frame_bad;
  logic                  eob, last_bit, par_exp, par_bad;
  logic                  start_frame, load_out, set_perr, set_serr;

  assign eob      = ({1'b0, Edge_count} == (p_l - 6'd1));
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign par_exp  = PAR_TYP ? ~(^data_sr) : (^data_sr);
  assign par_bad  = (Sampled_bit != par_exp);

  assign Sample_En = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    load_out    = 1'b0;
    set_perr    = 1'b0;
    set_serr    = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_nxt   = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (eob) state_nxt = Sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (eob && last_bit) state_nxt = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (eob) begin
          state_nxt = STOP;
          set_perr  = par_bad;
        end
      end
      STOP: begin
        if (eob) begin
          state_nxt = IDLE;
          if (Sampled_bit) load_out = ~frame_bad;
          else             set_serr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and payload datapath; the prescale is frozen for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_l          <= 6'd8;
      Edge_count   <= 5'd0;
      bit_cnt      <= '0;
      data_sr      <= '0;
      frame_bad    <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= load_out;
      Parity_Error <= set_perr;
      Stop_Error   <= set_serr;

      if (start_frame) p_l <= Prescale;

      if (state == IDLE || eob) Edge_count <= 5'd0;
      else                      Edge_count <= Edge_count + 5'd1;

      if (start_frame) begin
        bit_cnt   <= '0;
        frame_bad <= 1'b0;
      end else if (state == DATA && eob) begin
        data_sr <= DATA_WIDTH'({Sampled_bit, data_sr} >> 1);
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end

      if (set_perr) frame_bad <= 1'b1;
      if (load_out) P_DATA    <= data_sr;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven bit by bit, expected
// output events are queued and matched by an independent monitor.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       line = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       Sample_En;
  logic [4:0] Edge_count;
  logic [7:0] P_DATA;
  logic       Data_Valid, Parity_Error, Stop_Error;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    int         kind;   // 0 data valid, 1 parity error, 2 stop error
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (line),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Sampled_bit (line),
    .Sample_En   (Sample_En),
    .Edge_count  (Edge_count),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error  (Stop_Error)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    if (RST && (Data_Valid || Parity_Error || Stop_Error)) begin
      int k;
      exp_t e;
      k = Data_Valid ? 0 : (Parity_Error ? 1 : 2);
      if (sb.size() == 0) begin
        chk("unexpected_event_kind", k, 99);
      end else begin
        e = sb.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_pdata", P_DATA, e.data);
      end
    end
  end

  // Drives one frame aligned to the DUT's bit windows. kind 3 = no event.
  task automatic send(input int psc, input logic [7:0] data, input logic pen,
                      input logic ptyp, input logic pbit, input logic sbit,
                      input int kind, input logic [7:0] exp_data,
                      input int psc_mid, input int abort_bit);
    logic bits[0:10];
    int   nbits, t_start, ev_idx;
    exp_t e;
    nbits = pen ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = sbit;
    end else begin
      bits[9]  = sbit;
      bits[10] = 1'b1;
    end
    @(negedge CLK);
    Prescale = psc[5:0];
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    line     = 1'b0;
    for (int j = 0; j < nbits * psc; j++) begin
      @(negedge CLK);
      if (j == 0) begin
        t_start = cyc;
        chk("start_edge_count", Edge_count, 0);
        chk("start_sample_en", Sample_En, 1);
        ev_idx = (kind == 1) ? 9 : nbits - 1;
        if (kind < 3 && abort_bit < 0) begin
          e.kind = kind;
          e.cyc  = t_start + (ev_idx + 1) * psc;
          e.data = exp_data;
          sb.push_back(e);
        end
      end
      if (j == 3) chk("edge_count_3", Edge_count, 3);
      if (psc_mid != 0 && j == psc) Prescale = psc_mid[5:0];
      if (abort_bit >= 0 && j == abort_bit * psc + 2) begin
        RST = 1'b0;
        #1;
        chk("abort_sample_en", Sample_En, 0);
        chk("abort_edge_count", Edge_count, 0);
        chk("abort_pdata", P_DATA, 0);
        repeat (3) @(negedge CLK);
        line = 1'b1;
        RST  = 1'b1;
        repeat (4) @(negedge CLK);
        chk("abort_wait_idle", Sample_En, 0);
        return;
      end
      line = bits[j / psc];
    end
    @(negedge CLK);
    line = 1'b1;
  endtask

  initial begin
    line = 1'b1;
    RST  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_data_valid", Data_Valid, 0);
    chk("rst_parity_error", Parity_Error, 0);
    chk("rst_stop_error", Stop_Error, 0);
    chk("rst_pdata", P_DATA, 0);
    chk("rst_edge_count", Edge_count, 0);
    chk("rst_sample_en", Sample_En, 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // P=8 no parity 0xA5: valid 80 cycles after start detection
    send(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'hA5, 0, -1);
    // P=16 even parity, good frame; mid-frame prescale change ignored
    send(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h3C, 8, -1);
    // same frame with bad parity bit: parity error, P_DATA held
    send(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h3C, 0, -1);
    // P=8 bad stop bit on 0x55: stop error, P_DATA held
    send(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2, 8'h3C, 0, -1);
    repeat (3) @(negedge CLK);
    chk("stop_err_idle", Sample_En, 0);

    // start glitch: low for 2 cycles only
    @(negedge CLK);
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    line     = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    line = 1'b1;
    repeat (3) @(negedge CLK);
    chk("glitch_in_start", Sample_En, 1);
    repeat (8) @(negedge CLK);
    chk("glitch_back_idle", Sample_En, 0);
    chk("glitch_edge_count", Edge_count, 0);

    // back-to-back odd-parity frames at P=32
    send(32, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'h01, 0, -1);
    send(32, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'hFE, 0, -1);

    // reset during data bit 4 (frame bit 5), then a fresh frame
    send(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h3C, 0, 5);
    send(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h81, 0, -1);

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
